// File: rtl/vend_pkg.sv
// vend_pkg: shared types, widths and the coin decoder for the vending controller.
// Contents:
//   vend_state_e  - controller FSM states
//   NUM_SLOTS, ID_W, STOCK_W, PRICE_W, REC_W, CREDIT_W - record/credit geometry
//   CoinCode*     - 2-bit coin codes
//   coin_decode() - coin code to credit units
package vend_pkg;

  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned ID_W      = 3;
  localparam int unsigned STOCK_W   = 4;
  localparam int unsigned PRICE_W   = 4;
  localparam int unsigned REC_W     = ID_W + STOCK_W + PRICE_W;
  localparam int unsigned CREDIT_W  = 8;

  localparam logic [1:0] CoinCode1  = 2'b00;
  localparam logic [1:0] CoinCode2  = 2'b01;
  localparam logic [1:0] CoinCode5  = 2'b10;
  localparam logic [1:0] CoinCode10 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDispense,
    StChange
  } vend_state_e;

  function automatic logic [CREDIT_W-1:0] coin_decode(input logic [1:0] code);
    logic [CREDIT_W-1:0] units;
    case (code)
      CoinCode1:  units = 8'd1;
      CoinCode2:  units = 8'd2;
      CoinCode5:  units = 8'd5;
      CoinCode10: units = 8'd10;
      default:    units = 8'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_controller_slot.sv
// slot_reg: one product slot. Holds stock and price, applies a restock load or a
// single-unit decrement, and emits the packed record {ID, stock, price}.
// Ports:
//   clock, resetn        - clock, async active-low reset
//   load_i               - write load_stock_i/load_price_i
//   load_stock_i/price_i - restock values
//   dec_i                - remove one item (ignored at zero stock)
//   stock_o, price_o     - current contents
//   rec_o                - packed 11-bit record
module slot_reg
  import vend_pkg::*;
#(
  parameter logic [ID_W-1:0] ID = '0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load_i,
  input  logic [STOCK_W-1:0] load_stock_i,
  input  logic [PRICE_W-1:0] load_price_i,
  input  logic               dec_i,
  output logic [STOCK_W-1:0] stock_o,
  output logic [PRICE_W-1:0] price_o,
  output logic [REC_W-1:0]   rec_o
);

  logic [STOCK_W-1:0] stock_q, stock_d;
  logic [PRICE_W-1:0] price_q, price_d;

  always_comb begin
    stock_d = stock_q;
    price_d = price_q;
    if (load_i) begin
      stock_d = load_stock_i;
      price_d = load_price_i;
    end else if (dec_i && (stock_q != '0)) begin
      stock_d = stock_q - STOCK_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stock_q <= '0;
      price_q <= '0;
    end else begin
      stock_q <= stock_d;
      price_q <= price_d;
    end
  end

  assign stock_o = stock_q;
  assign price_o = price_q;
  assign rec_o   = {ID, stock_q, price_q};

endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending transaction controller feeding writeStuff.
// Collects coins, checks a selection against stock/price, dispenses, refunds change.
// Optional macro VEND_TIMEOUT_EN: auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
// Ports:
//   clock, resetn                  - clock, async active-low reset
//   coin_valid/coin_value          - coin strobe, code 00=1 01=2 10=5 11=10
//   sel_valid/sel_id               - selection strobe and slot
//   cancel                         - refund request
//   restock_valid/id/stock/price   - slot load, honoured in IDLE (restock_ready)
//   coin_reject, sel_error         - refusal pulses (same cycle as the strobe)
//   dispense_valid/dispense_id     - dispense pulse
//   change_valid/change_amount     - refund pulse
//   credit                         - current credit
//   p0..p4                         - slot records {id, stock, price}
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT = 255
`ifdef VEND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [ID_W-1:0]     restock_id,
  input  logic [STOCK_W-1:0]  restock_stock,
  input  logic [PRICE_W-1:0]  restock_price,
  output logic                restock_ready,
  output logic                coin_reject,
  output logic                sel_error,
  output logic                dispense_valid,
  output logic [ID_W-1:0]     dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic [REC_W-1:0]    p0,
  output logic [REC_W-1:0]    p1,
  output logic [REC_W-1:0]    p2,
  output logic [REC_W-1:0]    p3,
  output logic [REC_W-1:0]    p4
);

  localparam int unsigned     SumW         = CREDIT_W + 1;
  localparam logic [SumW-1:0] MaxCreditExt = SumW'(MAX_CREDIT);
  localparam logic [ID_W-1:0] LastSlot     = ID_W'(NUM_SLOTS - 1);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     sel_id_q, sel_id_d;

  logic [NUM_SLOTS-1:0] load, dec;
  logic [STOCK_W-1:0]   stock [NUM_SLOTS];
  logic [PRICE_W-1:0]   price [NUM_SLOTS];
  logic [REC_W-1:0]     rec   [NUM_SLOTS];

  logic [CREDIT_W-1:0] coin_units;
  logic [SumW-1:0]     coin_sum;
  logic                coin_fits;
  logic [STOCK_W-1:0]  sel_stock;
  logic [PRICE_W-1:0]  sel_price, disp_price;
  logic                sel_ok;
  logic                tmo_hit;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_reg #(
      .ID(ID_W'(i))
    ) u_slot (
      .clock       (clock),
      .resetn      (resetn),
      .load_i      (load[i]),
      .load_stock_i(restock_stock),
      .load_price_i(restock_price),
      .dec_i       (dec[i]),
      .stock_o     (stock[i]),
      .price_o     (price[i]),
      .rec_o       (rec[i])
    );
  end

  assign p0 = rec[0];
  assign p1 = rec[1];
  assign p2 = rec[2];
  assign p3 = rec[3];
  assign p4 = rec[4];

  // Slot lookups for the incoming selection and for the latched dispense slot.
  always_comb begin
    sel_stock  = '0;
    sel_price  = '0;
    disp_price = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_stock = stock[i];
        sel_price = price[i];
      end
      if (sel_id_q == ID_W'(i)) begin
        disp_price = price[i];
      end
    end
  end

  // Saturation is judged on the widened sum so the add itself can never wrap.
  assign coin_units = coin_decode(coin_value);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_units};
  assign coin_fits  = (coin_sum <= MaxCreditExt);

  // Uses pre-coin credit: a coin arriving alongside the selection cannot fund it.
  assign sel_ok = (sel_id <= LastSlot) && (sel_stock != '0) &&
                  (credit_q >= CREDIT_W'(sel_price));

`ifdef VEND_TIMEOUT_EN
  localparam logic [9:0] TmoLast = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if ((state_q == StCollect) && !coin_valid && !sel_valid) begin
      tmo_d = tmo_q + 10'd1;
    end
  end

  assign tmo_hit = (state_q == StCollect) && !coin_valid && !sel_valid && (tmo_q == TmoLast);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_id_d       = sel_id_q;
    load           = '0;
    dec            = '0;
    restock_ready  = 1'b0;
    coin_reject    = 1'b0;
    sel_error      = 1'b0;
    dispense_valid = 1'b0;
    dispense_id    = '0;
    change_valid   = 1'b0;
    change_amount  = '0;

    case (state_q)
      StIdle: begin
        restock_ready = 1'b1;
        if (coin_valid) begin
          // Coin beats a same-cycle restock; the restock is dropped.
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end else begin
            coin_reject = 1'b1;
          end
        end else if (restock_valid && (restock_id <= LastSlot)) begin
          load = NUM_SLOTS'(1) << restock_id;
        end
        if (sel_valid && (credit_q == '0)) begin
          sel_error = 1'b1;
        end
      end

      StCollect: begin
        if (coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            coin_reject = 1'b1;
          end
        end
        if (cancel) begin
          state_d = StChange;
        end else if (sel_valid) begin
          if (sel_ok) begin
            // Stock drops on this edge so p* already shows it during DISPENSE.
            sel_id_d = sel_id;
            dec      = NUM_SLOTS'(1) << sel_id;
            state_d  = StDispense;
          end else begin
            sel_error = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = StChange;
        end
      end

      StDispense: begin
        dispense_valid = 1'b1;
        dispense_id    = sel_id_q;
        coin_reject    = coin_valid;
        credit_d       = credit_q - CREDIT_W'(disp_price);
        state_d        = StChange;
      end

      StChange: begin
        coin_reject = coin_valid;
        if (credit_q != '0) begin
          change_valid  = 1'b1;
          change_amount = credit_q;
        end
        credit_d = '0;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      credit_q <= '0;
      sel_id_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_id_q <= sel_id_d;
    end
  end

  assign credit = credit_q;

endmodule
